// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller for loads and stores.
//
// Decodes LOAD/STORE from the memory-stage instruction and routes the access by
// address region:
//   addr[31:28] = 00x1 : DMEM (zero-stall; load data arrives one cycle later)
//   addr[31:28] = 001x : IMEM (stores only; 0011 writes DMEM and IMEM together)
//   addr[31:28] = 1000 : IO, via a request/response handshake FSM with a timeout
//   anything else      : no enables; loads return 0
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   inst, valid_in      memory-stage instruction and its valid
//   addr, wdata         effective byte address, store data (rs2)
//   stall               holds the memory stage and everything upstream
//   dmem_*/imem_*       word address, byte write enables, lane-aligned store data
//   dmem_dout           DMEM read data, one cycle after the address
//   io_req_*/io_rsp_*   IO request handshake and read response
//   ld_data, ld_valid   extended load result for writeback
//   io_timeout          one-cycle pulse when an IO access is abandoned
//   misalign            misaligned-access flag
//
// Build option: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses
// (enables forced off, no IO, loads return 0). Without it misalign is tied 0 and
// the offending low address bits are ignored.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst,
  input  logic              valid_in,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       dmem_dout,
  output logic              io_req_valid,
  input  logic              io_req_ready,
  output logic              io_req_we,
  output logic [31:0]       io_req_addr,
  output logic [31:0]       io_req_wdata,
  input  logic              io_rsp_valid,
  input  logic [31:0]       io_rdata,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              io_timeout,
  output logic              misalign
);

  localparam logic [15:0] TimeoutCnt = 16'(IO_TIMEOUT);
  localparam logic [31:0] TimeoutData = 32'hDEADBEEF;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StRsp} io_state_e;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [3:0] region;
  logic       is_load, is_store;
  logic       rgn_dmem, rgn_imem, rgn_io;

  assign opcode   = inst[6:2];
  assign funct3   = inst[14:12];
  assign region   = addr[31:28];
  assign is_load  = valid_in && (opcode == 5'b00000);
  assign is_store = valid_in && (opcode == 5'b01000);
  assign rgn_dmem = (region[3:2] == 2'b00) && region[0];
  assign rgn_imem = (region[3:1] == 3'b001);
  assign rgn_io   = (region == 4'b1000);

  // Instruction fields that play no part in memory access.
  logic unused_inst;
  assign unused_inst = ^{inst[31:15], inst[11:7], inst[1:0]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  io_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        pend_dmem_q, pend_dmem_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;

  logic idle;
  assign idle = (state_q == StIdle);

  // ---------------------------------------------------------------------------
  // Misaligned access detection
  // ---------------------------------------------------------------------------
  logic mis_raw;
`ifdef MEM_MISALIGN_TRAP_EN
  logic half_op, word_op;
  assign half_op  = (funct3 == F3Half) || (is_load && (funct3 == F3HalfU));
  assign word_op  = (funct3 == F3Word);
  assign mis_raw  = (is_load || is_store) &&
                    ((half_op && addr[0]) || (word_op && (addr[1:0] != 2'b00)));
  assign misalign = !rst && idle && mis_raw;
`else
  assign mis_raw  = 1'b0;
  assign misalign = 1'b0;
`endif

  logic io_go;
  assign io_go = idle && (is_load || is_store) && rgn_io && !mis_raw;

  // ---------------------------------------------------------------------------
  // Store byte enables and lane-aligned data
  // ---------------------------------------------------------------------------
  logic [3:0] be;

  always_comb begin
    be      = 4'b0000;
    mem_din = wdata;
    case (funct3)
      F3Byte: begin
        be      = 4'b0001 << addr[1:0];
        mem_din = {4{wdata[7:0]}};
      end
      F3Half: begin
        be      = 4'b0011 << {addr[1], 1'b0};
        mem_din = {2{wdata[15:0]}};
      end
      F3Word:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  logic st_ok;
  assign st_ok     = !rst && idle && is_store && !mis_raw;
  assign dmem_we   = (st_ok && rgn_dmem) ? be : 4'b0000;
  assign imem_we   = (st_ok && rgn_imem) ? be : 4'b0000;
  assign dmem_addr = addr[ADDR_W+1:2];
  assign imem_addr = addr[ADDR_W+1:2];

  // ---------------------------------------------------------------------------
  // Load extraction
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3Byte:  load_extract = {{24{b[7]}}, b};
      F3Half:  load_extract = {{16{h[15]}}, h};
      F3Word:  load_extract = word;
      F3ByteU: load_extract = {24'h0, b};
      F3HalfU: load_extract = {16'h0, h};
      default: load_extract = 32'h0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // IO FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  logic stall_raw, req_valid_raw, rsp_hit, tmo_hit;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_raw     = 1'b0;
    req_valid_raw = 1'b0;
    rsp_hit       = 1'b0;
    tmo_hit       = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = 16'h0;
        if (io_go) begin
          state_d   = StReq;
          stall_raw = 1'b1;
        end
      end
      StReq: begin
        req_valid_raw = 1'b1;
        stall_raw     = 1'b1;
        cnt_d         = cnt_q + 16'd1;
        // Acceptance takes priority over a coincident timeout.
        if (io_req_ready) begin
          if (req_we_q) begin
            state_d   = StIdle;
            stall_raw = 1'b0;
          end else begin
            state_d = StRsp;
          end
        end else if (cnt_q == TimeoutCnt) begin
          tmo_hit   = 1'b1;
          state_d   = StIdle;
          stall_raw = 1'b0;
        end
      end
      StRsp: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q + 16'd1;
        if (io_rsp_valid) begin
          rsp_hit   = 1'b1;
          state_d   = StIdle;
          stall_raw = 1'b0;
        end else if (cnt_q == TimeoutCnt) begin
          tmo_hit   = 1'b1;
          state_d   = StIdle;
          stall_raw = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured access attributes
  // ---------------------------------------------------------------------------
  always_comb begin
    // Every non-IO load (including misaligned/unmapped ones) returns one cycle later.
    pend_d      = idle && is_load && !io_go;
    pend_dmem_d = rgn_dmem && !mis_raw;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    if (idle && is_load) begin
      ld_f3_d  = funct3;
      ld_off_d = addr[1:0];
    end
    // Payload is frozen here so it stays stable for the whole request phase.
    if (io_go) begin
      req_we_d    = is_store;
      req_addr_d  = addr;
      req_wdata_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 16'h0;
      pend_q      <= 1'b0;
      pend_dmem_q <= 1'b0;
      ld_f3_q     <= 3'b000;
      ld_off_q    <= 2'b00;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_dmem_q <= pend_dmem_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stall        = !rst && stall_raw;
  assign io_req_valid = !rst && req_valid_raw;
  assign io_req_we    = req_we_q;
  assign io_req_addr  = req_addr_q;
  assign io_req_wdata = req_wdata_q;
  assign io_timeout   = !rst && tmo_hit;

  // A pending DMEM/unmapped load and an IO completion never coincide: the pending
  // load was accepted in IDLE, so the FSM cannot be in REQ/RSP in the next cycle.
  always_comb begin
    ld_valid = 1'b0;
    ld_data  = 32'h0;
    if (!rst) begin
      if (pend_q) begin
        ld_valid = 1'b1;
        ld_data  = pend_dmem_q ? load_extract(ld_f3_q, ld_off_q, dmem_dout) : 32'h0;
      end else if (rsp_hit) begin
        ld_valid = 1'b1;
        ld_data  = load_extract(ld_f3_q, ld_off_q, io_rdata);
      end else if (tmo_hit && !req_we_q) begin
        ld_valid = 1'b1;
        ld_data  = TimeoutData;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl. A second instance with IO_TIMEOUT=4
// shares all inputs and is observed only in the timeout scenarios.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 14;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpAlu   = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   inst, addr, wdata, dmem_dout, io_rdata;
  logic          valid_in, io_req_ready, io_rsp_valid;

  logic          stall, io_req_valid, io_req_we, ld_valid, io_timeout, misalign;
  logic [AW-1:0] dmem_addr, imem_addr;
  logic [3:0]    dmem_we, imem_we;
  logic [31:0]   mem_din, io_req_addr, io_req_wdata, ld_data;

  logic          t_stall, t_io_req_valid, t_io_req_we, t_ld_valid, t_io_timeout, t_misalign;
  logic [AW-1:0] t_dmem_addr, t_imem_addr;
  logic [3:0]    t_dmem_we, t_imem_we;
  logic [31:0]   t_mem_din, t_io_req_addr, t_io_req_wdata, t_ld_data;

  int n_run  = 0;
  int n_fail = 0;

  // Results recorded by run_io.
  int          stall_cnt, done_cyc, u2_done_cyc, tmo_cyc;
  logic        done_ldv, tmo_ldv, req_v1, req_we1;
  logic [31:0] done_data, tmo_data, req_addr1, req_wd1;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(AW), .IO_TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .inst(inst), .valid_in(valid_in), .addr(addr), .wdata(wdata),
    .stall(stall), .dmem_addr(dmem_addr), .imem_addr(imem_addr), .dmem_we(dmem_we),
    .imem_we(imem_we), .mem_din(mem_din), .dmem_dout(dmem_dout),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_we(io_req_we),
    .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata), .io_rsp_valid(io_rsp_valid),
    .io_rdata(io_rdata), .ld_data(ld_data), .ld_valid(ld_valid), .io_timeout(io_timeout),
    .misalign(misalign)
  );

  mem_access_ctrl #(.ADDR_W(AW), .IO_TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst(rst), .inst(inst), .valid_in(valid_in), .addr(addr), .wdata(wdata),
    .stall(t_stall), .dmem_addr(t_dmem_addr), .imem_addr(t_imem_addr), .dmem_we(t_dmem_we),
    .imem_we(t_imem_we), .mem_din(t_mem_din), .dmem_dout(dmem_dout),
    .io_req_valid(t_io_req_valid), .io_req_ready(io_req_ready), .io_req_we(t_io_req_we),
    .io_req_addr(t_io_req_addr), .io_req_wdata(t_io_req_wdata), .io_rsp_valid(io_rsp_valid),
    .io_rdata(io_rdata), .ld_data(t_ld_data), .ld_valid(t_ld_valid),
    .io_timeout(t_io_timeout), .misalign(t_misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    inst     = mk_inst(op, f3);
    addr     = a;
    wdata    = d;
    valid_in = 1'b1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    valid_in     = 1'b0;
    io_req_ready = 1'b0;
    io_rsp_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // One store cycle; checks enables, data and that no stall occurs.
  task automatic store_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] exp_dwe,
                           input logic [3:0] exp_iwe, input logic [31:0] exp_din);
    drive(OpStore, f3, a, d);
    @(negedge clk);
    check({tag, "_dwe"}, 32'(dmem_we), 32'(exp_dwe));
    check({tag, "_iwe"}, 32'(imem_we), 32'(exp_iwe));
    if (exp_dwe != 4'b0000) check({tag, "_din"}, mem_din, exp_din);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    next_cycle();
    valid_in = 1'b0;
  endtask

  // Load accepted in one cycle, result checked in the following cycle.
  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] dout, input logic [31:0] exp);
    drive(OpLoad, f3, a, 32'h0);
    dmem_dout = 32'h0;
    @(negedge clk);
    check({tag, "_acc_v"}, 32'(ld_valid), 32'd0);
    next_cycle();
    valid_in  = 1'b0;
    dmem_dout = dout;
    @(negedge clk);
    check({tag, "_v"}, 32'(ld_valid), 32'd1);
    check({tag, "_d"}, ld_data, exp);
    next_cycle();
  endtask

  // IO access with ready in cycle rc and response in cycle sc (cycle 0 = issue).
  task automatic run_io(input logic [6:0] op, input logic [31:0] a, input logic [31:0] d,
                        input int rc, input int sc, input logic [31:0] rd,
                        input int max_c, input bit stop_on_u2);
    stall_cnt   = 0;
    done_cyc    = -1;
    u2_done_cyc = -1;
    tmo_cyc     = -1;
    done_ldv    = 1'b0;
    done_data   = 32'h0;
    tmo_ldv     = 1'b0;
    tmo_data    = 32'h0;
    drive(op, 3'b010, a, d);
    for (int c = 0; c < max_c; c++) begin
      io_req_ready = (c == rc);
      io_rsp_valid = (c == sc);
      io_rdata     = (c == sc) ? rd : 32'h0;
      @(negedge clk);
      if (stall) stall_cnt++;
      else if (done_cyc < 0) begin
        done_cyc  = c;
        done_ldv  = ld_valid;
        done_data = ld_data;
      end
      if (!t_stall && u2_done_cyc < 0) u2_done_cyc = c;
      if (t_io_timeout && tmo_cyc < 0) begin
        tmo_cyc  = c;
        tmo_ldv  = t_ld_valid;
        tmo_data = t_ld_data;
      end
      if (c == 1) begin
        req_v1    = io_req_valid;
        req_we1   = io_req_we;
        req_addr1 = io_req_addr;
        req_wd1   = io_req_wdata;
      end
      next_cycle();
      if ((stop_on_u2 ? u2_done_cyc : done_cyc) >= 0) break;
    end
    valid_in     = 1'b0;
    io_req_ready = 1'b0;
    io_rsp_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    inst         = 32'h0;
    addr         = 32'h0;
    wdata        = 32'h0;
    valid_in     = 1'b0;
    dmem_dout    = 32'h0;
    io_req_ready = 1'b0;
    io_rsp_valid = 1'b0;
    io_rdata     = 32'h0;

    // Reset state, with a store presented while reset is high.
    drive(OpStore, 3'b010, 32'h3000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rst_dwe", 32'(dmem_we), 32'd0);
    check("rst_iwe", 32'(imem_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_reqv", 32'(io_req_valid), 32'd0);
    check("rst_ldv", 32'(ld_valid), 32'd0);
    check("rst_ldd", ld_data, 32'h0);
    check("rst_tmo", 32'(io_timeout), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    do_reset();

    // Stores.
    store_chk("sb", 3'b000, 32'h1000_0003, 32'h0000_00AB, 4'b1000, 4'b0000, 32'hABAB_ABAB);
    store_chk("sw_both", 3'b010, 32'h3000_0004, 32'hCAFE_F00D, 4'b1111, 4'b1111,
              32'hCAFE_F00D);
    drive(OpStore, 3'b010, 32'h3000_0004, 32'h0);
    @(negedge clk);
    check("sw_both_iaddr", 32'(imem_addr), 32'd1);
    next_cycle();
    store_chk("sh", 3'b001, 32'h1000_0006, 32'h0000_1234, 4'b1100, 4'b0000, 32'h1234_1234);
    store_chk("sw_imem", 3'b010, 32'h2000_0008, 32'h5555_AAAA, 4'b0000, 4'b1111,
              32'h5555_AAAA);
    store_chk("s_badf3", 3'b011, 32'h1000_0000, 32'h1, 4'b0000, 4'b0000, 32'h0);
    store_chk("s_unmap", 3'b010, 32'h4000_0000, 32'h1, 4'b0000, 4'b0000, 32'h0);
    drive(OpAlu, 3'b010, 32'h1000_0000, 32'h1);
    @(negedge clk);
    check("alu_dwe", 32'(dmem_we), 32'd0);
    next_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    check("alu_ldv", 32'(ld_valid), 32'd0);
    next_cycle();

    // Loads.
    load_chk("lh", 3'b001, 32'h1000_0002, 32'h8001_5555, 32'hFFFF_8001);
    load_chk("lbu", 3'b100, 32'h1000_0001, 32'h0000_F000, 32'h0000_00F0);
    load_chk("lb", 3'b000, 32'h1000_0001, 32'h0000_8000, 32'hFFFF_FF80);
    load_chk("lhu", 3'b101, 32'h1000_0000, 32'h1234_9ABC, 32'h0000_9ABC);
    load_chk("l_badf3", 3'b011, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0);
    load_chk("l_unmap", 3'b010, 32'h5000_0000, 32'hFFFF_FFFF, 32'h0);

    // Misaligned accesses.
    drive(OpStore, 3'b010, 32'h1000_0001, 32'h0BAD_F00D);
    @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_sw_flag", 32'(misalign), 32'd1);
    check("mis_sw_dwe", 32'(dmem_we), 32'd0);
`else
    check("mis_sw_flag", 32'(misalign), 32'd0);
    check("mis_sw_dwe", 32'(dmem_we), 32'hF);
`endif
    next_cycle();
    valid_in = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    load_chk("mis_lh", 3'b001, 32'h1000_0003, 32'h8001_0000, 32'h0);
`else
    load_chk("mis_lh", 3'b001, 32'h1000_0003, 32'h8001_0000, 32'hFFFF_8001);
`endif

    // IO load: ready 3 cycles after the request starts, response 2 cycles later.
    do_reset();
    run_io(OpLoad, 32'h8000_0000, 32'h0, 4, 6, 32'h1234_5678, 20, 1'b0);
    check("io_ld_stall_cnt", 32'(stall_cnt), 32'd6);
    check("io_ld_done_cyc", 32'(done_cyc), 32'd6);
    check("io_ld_v", 32'(done_ldv), 32'd1);
    check("io_ld_d", done_data, 32'h1234_5678);
    check("io_ld_reqv", 32'(req_v1), 32'd1);
    check("io_ld_reqwe", 32'(req_we1), 32'd0);
    check("io_ld_reqaddr", req_addr1, 32'h8000_0000);
    @(negedge clk);
    check("io_ld_after_v", 32'(ld_valid), 32'd0);
    check("io_ld_after_stall", 32'(stall), 32'd0);
    next_cycle();

    // IO store accepted in the same cycle the short-timeout instance would expire.
    do_reset();
    run_io(OpStore, 32'h8000_0004, 32'h1122_3344, 5, -1, 32'h0, 20, 1'b0);
    check("io_st_done_cyc", 32'(done_cyc), 32'd5);
    check("io_st_stall_cnt", 32'(stall_cnt), 32'd5);
    check("io_st_ldv", 32'(done_ldv), 32'd0);
    check("io_st_reqwe", 32'(req_we1), 32'd1);
    check("io_st_reqwd", req_wd1, 32'h1122_3344);
    check("io_st_to_done", 32'(u2_done_cyc), 32'd5);
    check("io_st_to_notmo", 32'(tmo_cyc), 32'hFFFF_FFFF);

    // IO load with no ready on the IO_TIMEOUT=4 instance.
    do_reset();
    run_io(OpLoad, 32'h8000_0010, 32'h0, -1, -1, 32'h0, 20, 1'b1);
    check("tmo_cyc", 32'(tmo_cyc), 32'd5);
    check("tmo_ldv", 32'(tmo_ldv), 32'd1);
    check("tmo_data", tmo_data, 32'hDEAD_BEEF);
    check("tmo_done_cyc", 32'(u2_done_cyc), 32'd5);
    @(negedge clk);
    check("tmo_after_pulse", 32'(t_io_timeout), 32'd0);
    check("tmo_after_reqv", 32'(t_io_req_valid), 32'd0);
    check("tmo_after_stall", 32'(t_stall), 32'd0);
    check("tmo_main_waiting", 32'(stall), 32'd1);
    next_cycle();

    // Reset asserted while in RSP, then a fresh IO access.
    do_reset();
    drive(OpLoad, 3'b010, 32'h8000_0030, 32'h0);
    next_cycle();
    io_req_ready = 1'b1;
    next_cycle();
    io_req_ready = 1'b0;
    @(negedge clk);
    check("rsp_pre_reqv", 32'(io_req_valid), 32'd0);
    check("rsp_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rsp_rst_reqv", 32'(io_req_valid), 32'd0);
    check("rsp_rst_stall", 32'(stall), 32'd0);
    check("rsp_rst_ldv", 32'(ld_valid), 32'd0);
    next_cycle();
    rst      = 1'b0;
    valid_in = 1'b0;
    next_cycle();
    run_io(OpLoad, 32'h8000_0020, 32'h0, 1, 2, 32'hA5A5_0001, 20, 1'b0);
    check("post_rst_done_cyc", 32'(done_cyc), 32'd2);
    check("post_rst_ldv", 32'(done_ldv), 32'd1);
    check("post_rst_ldd", done_data, 32'hA5A5_0001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the DMEM/IMEM word-address width.
REQ-002 SHALL have parameter IO_TIMEOUT, default 255, the maximum IO wait cycles (1..65535).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 inst  input  32  instruction in the memory stage.
REQ-006 valid_in  input  1  inst/addr/wdata are valid this cycle.
REQ-007 addr  input  32  effective byte address.
REQ-008 wdata  input  32  store data (rs2).
REQ-009 stall  output  1  hold the memory stage and everything upstream.
REQ-010 dmem_addr, imem_addr  output  ADDR_W  addr[ADDR_W+1:2].
REQ-011 dmem_we, imem_we  output  4  byte write enables.
REQ-012 mem_din  output  32  lane-aligned store data.
REQ-013 dmem_dout  input  32  DMEM read data, valid one cycle after the address.
REQ-014 io_req_valid / io_req_ready  out / in  1  IO request handshake.
REQ-015 io_req_we, io_req_addr, io_req_wdata  output  1/32/32  IO request payload.
REQ-016 io_rsp_valid, io_rdata  input  1/32  IO read response.
REQ-017 ld_data, ld_valid  output  32/1  extended load result for writeback.
REQ-018 io_timeout  output  1  one-cycle pulse when an IO access is abandoned.
REQ-019 misalign  output  1  misaligned-access flag (see REQ-036).

Function
REQ-020 Decode: opcode inst[6:2]=00000 SHALL be a LOAD and 01000 a STORE; funct3=inst[14:12]; every other opcode SHALL be a no-op with all enables 0.
REQ-021 Regions by addr[31:28]: 00x1 DMEM; STORE to 001x IMEM; 1000 IO; any other region SHALL produce no enables and, for a LOAD, ld_data=0.
REQ-022 A STORE to 0011 SHALL write both DMEM and IMEM in the same cycle.
REQ-023 Byte enables: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111; undefined funct3 SHALL give 0000.
REQ-024 mem_din: SB byte replicated x4; SH half replicated x2; SW unchanged.
REQ-025 DMEM loads SHALL cost 0 stall cycles; funct3 and addr[1:0] SHALL be registered so ld_data/ld_valid appear exactly 1 cycle after acceptance.
REQ-026 Extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough; undefined load funct3 SHALL return 0.
REQ-027 IO FSM states: IDLE, REQ, RSP.
REQ-028 IDLE->REQ on a valid IO access; stall SHALL assert combinationally that same cycle.
REQ-029 REQ: io_req_valid=1 with a payload that SHALL stay stable until io_req_ready; a STORE then goes to IDLE, a LOAD goes to RSP.
REQ-030 RSP: io_rsp_valid is sampled only in RSP; on it, ld_data=io_rdata extended per REQ-026, ld_valid=1 for 1 cycle, next state IDLE.
REQ-031 stall SHALL be 1 in REQ and RSP, and SHALL drop in the cycle ld_valid or store acceptance occurs.
REQ-032 A 16-bit wait counter SHALL clear on leaving IDLE and count in REQ and RSP; reaching IO_TIMEOUT SHALL pulse io_timeout, return 32'hDEADBEEF for loads (ld_valid=1) and go to IDLE.
REQ-033 io_req_ready and timeout in the same cycle: acceptance SHALL win.

Reset
REQ-034 On rst, at any time including mid-IO: state=IDLE, counter=0, and stall, io_req_valid, ld_valid, io_timeout, misalign all 0; ld_data=0; the in-flight access is dropped.
REQ-035 Write enables SHALL be 0 while rst is high.

Configuration
REQ-036 MEM_MISALIGN_TRAP_EN defined: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0, SHALL assert misalign for 1 cycle, force enables to 0 and start no IO; a load returns ld_data=0 with ld_valid=1 after 1 cycle. Undefined: misalign is tied 0 and the offending low address bits are treated as 0.

Verification
REQ-037 SB addr=0x10000003 wdata=0x000000AB -> dmem_we=1000, mem_din=0xABABABAB, stall=0.
REQ-038 LH addr=0x10000002, dmem_dout=0x8001xxxx next cycle -> ld_data=0xFFFF8001, ld_valid=1 one cycle after acceptance.
REQ-039 SW addr=0x30000004 -> dmem_we=imem_we=1111, imem_addr=1.
REQ-040 LW addr=0x80000000, io_req_ready after 3 cycles, io_rsp_valid 2 cycles later with 0x12345678 -> stall high 6 cycles, ld_data=0x12345678.
REQ-041 IO load, IO_TIMEOUT=4, no ready -> io_timeout pulse, ld_data=0xDEADBEEF, FSM back in IDLE.
REQ-042 rst asserted in RSP -> io_req_valid/stall 0 immediately; next IO access completes normally.
